// File: rtl/dbg_seq_streamer.sv
// Debug frame generator for the UART TX path: emits "DBG: ", N_VALUES counting
// values (hex ASCII or raw bytes), then "\r\n", with repeat, abort and a status pulse interface.
module dbg_seq_streamer #(
  parameter int N_VALUES   = 16,
  parameter int VALUE_W    = 8,
  parameter int HEX_ASCII  = 1,
  parameter int GAP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic               start,
  input  logic               abort,
  input  logic               mode_repeat,
  input  logic [VALUE_W-1:0] base_value,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [2:0]         dbg_state
);

  // Handshake: a byte moves on a rising clk edge with tx_valid & tx_ready; once
  // tx_valid rises, tx_data holds and tx_valid stays high until that transfer happens.

  localparam int NIB   = VALUE_W / 4;
  localparam int NB    = VALUE_W / 8;
  localparam int CHARS = (HEX_ASCII != 0) ? NIB + 1 : NB;
  localparam int KW    = (N_VALUES > 1) ? $clog2(N_VALUES) : 1;
  localparam int BW    = $clog2(VALUE_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_VAL  = 2'd2,
    S_EOL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         sub_q, sub_d;
  logic [KW-1:0]      k_q, k_d;
  logic [VALUE_W-1:0] val_q, val_d;
  logic [15:0]        gap_q, gap_d;
  logic               abort_pend_q, abort_pend_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               sync1_q, sync2_q, trig_prev_q;

  logic               trig_evt, start_evt, in_gap, xfer, abort_now;
  logic [7:0]         byte_sel;
  logic [BW-1:0]      lsb;
  logic [3:0]         nib;

  assign trig_evt  = sync2_q & ~trig_prev_q;
  assign start_evt = start | trig_evt;
  assign in_gap    = (gap_q != 16'd0);
  assign tx_valid  = (state_q != S_IDLE) && !in_gap;
  assign xfer      = tx_valid & tx_ready;
  assign abort_now = abort | abort_pend_q;

  assign tx_data   = (state_q == S_IDLE) ? 8'h00 : byte_sel;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign dbg_state = {in_gap, state_q};

  // Byte currently offered, chosen from phase, character index and value.
  always_comb begin
    byte_sel = 8'h00;
    lsb      = '0;
    nib      = 4'h0;
    case (state_q)
      S_HDR: begin
        case (sub_q)
          4'd0:    byte_sel = 8'h44;
          4'd1:    byte_sel = 8'h42;
          4'd2:    byte_sel = 8'h47;
          4'd3:    byte_sel = 8'h3A;
          default: byte_sel = 8'h20;
        endcase
      end
      S_VAL: begin
        if (HEX_ASCII != 0) begin
          if (sub_q >= 4'(NIB)) begin
            byte_sel = 8'h20;
          end else begin
            lsb      = BW'((NIB - 1 - int'(sub_q)) * 4);
            nib      = val_q[lsb +: 4];
            byte_sel = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
          end
        end else begin
          lsb      = BW'((NB - 1 - int'(sub_q)) * 8);
          byte_sel = val_q[lsb +: 8];
        end
      end
      S_EOL:   byte_sel = (sub_q == 4'd0) ? 8'h0D : 8'h0A;
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    k_d          = k_q;
    val_d        = val_q;
    gap_d        = in_gap ? (gap_q - 16'd1) : gap_q;
    abort_pend_d = abort_pend_q | (abort & busy);
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    if (state_q == S_IDLE) begin
      abort_pend_d = 1'b0;
      if (start_evt) begin
        state_d = S_HDR;
        sub_d   = 4'd0;
        k_d     = '0;
        val_d   = base_value;
        gap_d   = 16'd0;
      end
    end else if (xfer) begin
      gap_d = 16'(GAP_CYCLES);
      if (state_q == S_EOL && sub_q == 4'd1) begin
        // Completing the frame outranks a coincident abort.
        done_d       = 1'b1;
        abort_pend_d = 1'b0;
        sub_d        = 4'd0;
        k_d          = '0;
        if (mode_repeat && !abort_now) begin
          state_d = S_HDR;
        end else begin
          state_d = S_IDLE;
          gap_d   = 16'd0;
        end
      end else if (abort_now) begin
        state_d      = S_IDLE;
        aborted_d    = 1'b1;
        abort_pend_d = 1'b0;
        gap_d        = 16'd0;
      end else begin
        case (state_q)
          S_HDR: begin
            if (sub_q == 4'd4) begin
              state_d = S_VAL;
              sub_d   = 4'd0;
            end else begin
              sub_d = sub_q + 4'd1;
            end
          end
          S_VAL: begin
            if (sub_q == 4'(CHARS - 1)) begin
              sub_d = 4'd0;
              val_d = val_q + VALUE_W'(1);
              if (k_q == KW'(N_VALUES - 1)) begin
                state_d = S_EOL;
                k_d     = '0;
              end else begin
                k_d = k_q + KW'(1);
              end
            end else begin
              sub_d = sub_q + 4'd1;
            end
          end
          default: sub_d = sub_q + 4'd1;
        endcase
      end
    end else if (in_gap && abort_now) begin
      state_d      = S_IDLE;
      aborted_d    = 1'b1;
      abort_pend_d = 1'b0;
      gap_d        = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sub_q        <= 4'd0;
      k_q          <= '0;
      val_q        <= '0;
      gap_q        <= 16'd0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      trig_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sub_q        <= sub_d;
      k_q          <= k_d;
      val_q        <= val_d;
      gap_q        <= gap_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      sync1_q      <= trigger;
      sync2_q      <= sync1_q;
      trig_prev_q  <= sync2_q;
    end
  end

endmodule

// File: tb/tb_dbg_seq_streamer.sv
// Bench for dbg_seq_streamer: three configurations, expected bytes queued by the
// drivers and checked by a negedge monitor that also tracks handshake and pulses.
module tb_dbg_seq_streamer;

  logic       clk = 1'b0;
  logic       reset;
  logic       trigger [3];
  logic       start [3];
  logic       abort [3];
  logic       mode_repeat [3];
  logic       tx_ready [3];
  logic [7:0] base_value [3];
  logic       tx_valid [3];
  logic [7:0] tx_data [3];
  logic       busy [3];
  logic       done [3];
  logic       aborted [3];
  logic [2:0] dbg_state [3];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int xfer_cnt [3];
  int done_cnt [3];
  int abort_cnt [3];
  int last_xfer [3];
  bit chk_gap [3];
  bit ignore [3];
  logic       held_v [3];
  logic [7:0] held_d [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbg_seq_streamer #(.N_VALUES(16), .VALUE_W(8), .HEX_ASCII(1), .GAP_CYCLES(16)) u_dut0 (
    .clk(clk), .reset(reset), .trigger(trigger[0]), .start(start[0]), .abort(abort[0]),
    .mode_repeat(mode_repeat[0]), .base_value(base_value[0]), .tx_ready(tx_ready[0]),
    .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .busy(busy[0]), .done(done[0]),
    .aborted(aborted[0]), .dbg_state(dbg_state[0]));

  dbg_seq_streamer #(.N_VALUES(4), .VALUE_W(8), .HEX_ASCII(0), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .trigger(trigger[1]), .start(start[1]), .abort(abort[1]),
    .mode_repeat(mode_repeat[1]), .base_value(base_value[1]), .tx_ready(tx_ready[1]),
    .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .busy(busy[1]), .done(done[1]),
    .aborted(aborted[1]), .dbg_state(dbg_state[1]));

  dbg_seq_streamer #(.N_VALUES(2), .VALUE_W(8), .HEX_ASCII(1), .GAP_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .trigger(trigger[2]), .start(start[2]), .abort(abort[2]),
    .mode_repeat(mode_repeat[2]), .base_value(base_value[2]), .tx_ready(tx_ready[2]),
    .tx_valid(tx_valid[2]), .tx_data(tx_data[2]), .busy(busy[2]), .done(done[2]),
    .aborted(aborted[2]), .dbg_state(dbg_state[2]));

  function automatic int gap_of(input int id);
    case (id)
      0:       return 16;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [7:0] b);
    case (id)
      0:       exp_q0.push_back(b);
      1:       exp_q1.push_back(b);
      default: exp_q2.push_back(b);
    endcase
  endtask

  function automatic int q_size(input int id);
    case (id)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic check_byte(input int id, input logic [7:0] act);
    logic [7:0] e;
    if (q_size(id) == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_byte dut%0d: got %0h, expected none", id, act);
    end else begin
      case (id)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      chk($sformatf("byte dut%0d", id), {24'h0, act}, {24'h0, e});
    end
  endtask

  task automatic push_value(input int id, input logic [7:0] v);
    push(id, hex_char(v[7:4]));
    push(id, hex_char(v[3:0]));
    push(id, 8'h20);
  endtask

  task automatic push_hdr(input int id);
    push(id, 8'h44); push(id, 8'h42); push(id, 8'h47); push(id, 8'h3A); push(id, 8'h20);
  endtask

  task automatic push_frame(input int id, input logic [7:0] base, input int n);
    push_hdr(id);
    for (int k = 0; k < n; k++) push_value(id, base + 8'(k));
    push(id, 8'h0D);
    push(id, 8'h0A);
  endtask

  // Monitor: transfers are decided at the negedge before the edge that performs them.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        held_v[i] = 1'b0;
      end else begin
        if (held_v[i]) begin
          chk($sformatf("hold_valid dut%0d", i), {31'h0, tx_valid[i]}, 32'h1);
          chk($sformatf("hold_data dut%0d", i), {24'h0, tx_data[i]}, {24'h0, held_d[i]});
        end
        if (tx_valid[i] && tx_ready[i]) begin
          if (!ignore[i]) check_byte(i, tx_data[i]);
          if (chk_gap[i] && last_xfer[i] >= 0)
            chk($sformatf("spacing dut%0d", i), cyc - last_xfer[i], gap_of(i) + 1);
          last_xfer[i] = cyc;
          xfer_cnt[i]++;
          held_v[i] = 1'b0;
        end else if (tx_valid[i]) begin
          held_v[i] = 1'b1;
          held_d[i] = tx_data[i];
        end else begin
          held_v[i] = 1'b0;
        end
        if (done[i]) done_cnt[i]++;
        if (aborted[i]) begin
          abort_cnt[i]++;
          chk($sformatf("aborted_busy dut%0d", i), {31'h0, busy[i]}, 32'h0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int id);
    start[id] = 1'b1;
    tick(1);
    start[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, input int target, input int budget, input bit rnd);
    int n = 0;
    while (done_cnt[id] < target && n < budget) begin
      if (rnd) tx_ready[id] = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    tx_ready[id] = 1'b1;
    chk($sformatf("done_timeout dut%0d", id), 32'(done_cnt[id] >= target), 32'h1);
  endtask

  initial begin
    int d0, a0, x0, n;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trigger[i] = 1'b0; start[i] = 1'b0; abort[i] = 1'b0; mode_repeat[i] = 1'b0;
      tx_ready[i] = 1'b1; base_value[i] = 8'h00;
      xfer_cnt[i] = 0; done_cnt[i] = 0; abort_cnt[i] = 0; last_xfer[i] = -1;
      chk_gap[i] = 1'b0; ignore[i] = 1'b0; held_v[i] = 1'b0; held_d[i] = 8'h00;
    end
    tick(3);
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", {31'h0, tx_valid[i]}, 32'h0);
      chk("rst_data", {24'h0, tx_data[i]}, 32'h0);
      chk("rst_busy_done_abort", {29'h0, busy[i], done[i], aborted[i]}, 32'h0);
    end
    reset = 1'b0;
    tick(2);

    // 1: default frame, ready held high, 17-cycle byte spacing
    push_frame(0, 8'h00, 16);
    chk_gap[0] = 1'b1;
    pulse_start(0);
    chk("start_latency_valid", {31'h0, tx_valid[0]}, 32'h1);
    chk("start_latency_busy", {31'h0, busy[0]}, 32'h1);
    chk("start_latency_data", {24'h0, tx_data[0]}, 32'h44);
    wait_done(0, 1, 2000, 1'b0);
    tick(20);
    chk("t1_done_once", done_cnt[0], 1);
    chk("t1_busy_low", {31'h0, busy[0]}, 32'h0);
    chk("t1_queue_empty", q_size(0), 0);
    chk_gap[0] = 1'b0;

    // 2: raw bytes with wrap, back-to-back
    base_value[1] = 8'hFE;
    push(1, 8'h44); push(1, 8'h42); push(1, 8'h47); push(1, 8'h3A); push(1, 8'h20);
    push(1, 8'hFE); push(1, 8'hFF); push(1, 8'h00); push(1, 8'h01); push(1, 8'h0D); push(1, 8'h0A);
    chk_gap[1] = 1'b1;
    pulse_start(1);
    wait_done(1, 1, 200, 1'b0);
    tick(5);
    chk("t2_queue_empty", q_size(1), 0);
    chk("t2_done_once", done_cnt[1], 1);
    chk("t2_busy_low", {31'h0, busy[1]}, 32'h0);

    // 3: random backpressure, same byte order as test 1
    push_frame(0, 8'h00, 16);
    pulse_start(0);
    wait_done(0, 2, 6000, 1'b1);
    tick(20);
    chk("t3_queue_empty", q_size(0), 0);
    chk("t3_done_cnt", done_cnt[0], 2);

    // 4: repeat mode continues counting, clearing it ends after the current frame
    base_value[2] = 8'h10;
    mode_repeat[2] = 1'b1;
    push_frame(2, 8'h10, 2);
    push_frame(2, 8'h12, 2);
    chk_gap[2] = 1'b1;
    pulse_start(2);
    wait_done(2, 1, 300, 1'b0);
    chk("t4_busy_through_repeat", {31'h0, busy[2]}, 32'h1);
    mode_repeat[2] = 1'b0;
    wait_done(2, 2, 300, 1'b0);
    tick(60);
    chk("t4_done_cnt", done_cnt[2], 2);
    chk("t4_queue_empty", q_size(2), 0);
    chk("t4_busy_low", {31'h0, busy[2]}, 32'h0);

    // 5: abort during the 3rd value with ready low
    d0 = done_cnt[0];
    a0 = abort_cnt[0];
    x0 = xfer_cnt[0];
    push_hdr(0);
    push_value(0, 8'h00);
    push_value(0, 8'h01);
    push(0, 8'h30);
    pulse_start(0);
    n = 0;
    while (xfer_cnt[0] - x0 < 11 && n < 400) begin tick(1); n++; end
    tx_ready[0] = 1'b0;
    chk("t5_reach_value3", 32'(xfer_cnt[0] - x0 >= 11), 32'h1);
    n = 0;
    while (!tx_valid[0] && n < 40) begin tick(1); n++; end
    chk("t5_valid_pending", {31'h0, tx_valid[0]}, 32'h1);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    tick(5);
    chk("t5_valid_held", {31'h0, tx_valid[0]}, 32'h1);
    chk("t5_no_early_abort", abort_cnt[0] - a0, 0);
    tx_ready[0] = 1'b1;
    tick(3);
    chk("t5_aborted_pulse", abort_cnt[0] - a0, 1);
    chk("t5_busy_low", {31'h0, busy[0]}, 32'h0);
    tick(40);
    chk("t5_queue_empty", q_size(0), 0);
    chk("t5_no_done", done_cnt[0] - d0, 0);
    chk("t5_single_abort", abort_cnt[0] - a0, 1);

    // 6: bounced trigger plus ignored starts give one frame
    d0 = done_cnt[0];
    push_frame(0, 8'h00, 16);
    trigger[0] = 1'b1;
    n = 0;
    while (!tx_valid[0] && n < 4) begin
      tick(1);
      n++;
      trigger[0] = 1'b0;
    end
    chk("t6_trigger_latency", {31'h0, tx_valid[0]}, 32'h1);
    tick(30);
    pulse_start(0);
    trigger[0] = 1'b1;
    tick(3);
    trigger[0] = 1'b0;
    wait_done(0, d0 + 1, 2000, 1'b0);
    tick(100);
    chk("t6_one_frame", done_cnt[0] - d0, 1);
    chk("t6_queue_empty", q_size(0), 0);

    // 6b: asynchronous reset mid-frame
    ignore[0] = 1'b1;
    pulse_start(0);
    tick(60);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_valid", {31'h0, tx_valid[0]}, 32'h0);
    chk("t6_rst_data", {24'h0, tx_data[0]}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy[0]}, 32'h0);
    tick(2);
    reset = 1'b0;
    x0 = xfer_cnt[0];
    tick(50);
    chk("t6_no_resume", xfer_cnt[0] - x0, 0);
    chk("t6_idle_after_reset", {31'h0, busy[0]}, 32'h0);
    ignore[0] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
